// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a write-pending (busy) scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.

module regfile_mp_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic                     rst_i,
    input  logic                     rd_en_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        st_data_i,
    input  logic                     st_busy_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_busy_o
);
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

`ifdef REGFILE_BYPASS_EN
    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                byp_hit  = 1'b1;
                byp_data = wr_data_i[k*DATA_W +: DATA_W];
            end
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign byp_hit   = 1'b0;
    assign byp_data  = '0;
`endif

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (rd_en_i && !rst_i && (rd_addr_i != '0)) begin
            if (byp_hit) begin
                rd_data_o = byp_data;
            end else begin
                rd_data_o = st_data_i;
                rd_busy_o = st_busy_i;
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [ADDR_W:0]          busy_cnt_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    wr_req_t [NUM_WR-1:0]         wr_req;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DEPTH-1:0]             set_vec, clr_vec;
    logic [CNT_W-1:0]             busy_cnt_q, busy_cnt_d;
    logic                         set_inc;
    logic [CNT_W-1:0]             clr_dec;
    logic [CNT_W:0]               cnt_sum;

    always_comb begin
        wr_req = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_req[k].en   = wr_en_i[k];
            wr_req[k].addr = wr_addr_i[k*ADDR_W +: ADDR_W];
            wr_req[k].data = wr_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_comb begin
        mem_d   = mem_q;
        set_vec = '0;
        clr_vec = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_req[k].en) begin
                mem_d[wr_req[k].addr]   = wr_req[k].data;
                clr_vec[wr_req[k].addr] = 1'b1;
            end
        end
        if (iss_en_i) begin
            set_vec[iss_addr_i] = 1'b1;
        end
        mem_d[0]   = '0;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
        // A new producer supersedes a same-cycle writeback of the old one.
        busy_d = set_vec | (busy_q & ~clr_vec);
    end

    // Count only real transitions so clears of idle entries never underflow.
    always_comb begin
        set_inc = |(set_vec & ~busy_q);
        clr_dec = '0;
        for (int a = 1; a < DEPTH; a++) begin
            if (busy_q[a] && clr_vec[a] && !set_vec[a]) begin
                clr_dec = clr_dec + CNT_W'(1);
            end
        end
        cnt_sum = {1'b0, busy_cnt_q} + (CNT_W+1)'(set_inc);
        if (cnt_sum < {1'b0, clr_dec}) begin
            busy_cnt_d = '0;
        end else if ((cnt_sum - {1'b0, clr_dec}) > {1'b0, CNT_MAX}) begin
            busy_cnt_d = CNT_MAX;
        end else begin
            busy_cnt_d = CNT_W'(cnt_sum - {1'b0, clr_dec});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q      <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd (
            .rst_i     (rst_i),
            .rd_en_i   (rd_en_i[j]),
            .rd_addr_i (rd_addr_i[j*ADDR_W +: ADDR_W]),
            .st_data_i (mem_q[rd_addr_i[j*ADDR_W +: ADDR_W]]),
            .st_busy_i (busy_q[rd_addr_i[j*ADDR_W +: ADDR_W]]),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_data_o (rd_data_o[j*DATA_W +: DATA_W]),
            .rd_busy_o (rd_busy_o[j])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, x0, issue/writeback, port priority, scoreboard count.
// Expectations adapt to the REGFILE_BYPASS_EN build.

module tb_regfile_mp;
    logic        clk;
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_cnt_o (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge (state from the last rising edge is visible) and clear inputs.
    task automatic step();
        @(negedge clk);
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic rd(input int j, input logic [4:0] a);
        rd_en[j] = 1'b1;
        rd_addr[j*5 +: 5] = a;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        wr_en[k] = 1'b1;
        wr_addr[k*5 +: 5] = a;
        wr_data[k*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rdd(input int j);
        return rd_data[j*32 +: 32];
    endfunction

    initial begin
        rst = 1'b1;
        step();
        step();
        // Reset cycle: writes and issues ignored, reads gated.
        wr(0, 5'd4, 32'h55); iss_en = 1'b1; iss_addr = 5'd3; rd(0, 5'd4);
        #1;
        chk("rst_rd_data", rdd(0), 32'h0);
        chk("rst_rd_busy", 32'(rd_busy[0]), 32'h0);

        step(); rst = 1'b0;
        #1 chk("post_rst_cnt", 32'(busy_cnt), 32'h0);
        for (int a = 0; a < 32; a++) begin
            step(); rd(0, 5'(a)); rd(1, 5'(31 - a));
            #1;
            chk("init_p0", rdd(0), 32'h0);
            chk("init_p1", rdd(1), 32'h0);
            chk("init_busy", 32'(rd_busy), 32'h0);
        end

        // x0 is hardwired.
        step(); wr(0, 5'd0, 32'hDEADBEEF); rd(0, 5'd0);
        #1 chk("x0_same", rdd(0), 32'h0);
        step(); rd(0, 5'd0);
        #1 chk("x0_next", rdd(0), 32'h0);

        // Issue x5, then writeback.
        step(); iss_en = 1'b1; iss_addr = 5'd5; rd(0, 5'd5);
        #1 chk("iss_pre_busy", 32'(rd_busy[0]), 32'h0);
        step(); rd(0, 5'd5);
        #1;
        chk("x5_cnt1", 32'(busy_cnt), 32'd1);
        chk("x5_busy", 32'(rd_busy[0]), 32'h1);
        step(); wr(0, 5'd5, 32'h1234); rd(1, 5'd5);
        #1;
        chk("x5_wb_data", rdd(1), BYP ? 32'h1234 : 32'h0);
        chk("x5_wb_busy", 32'(rd_busy[1]), BYP ? 32'h0 : 32'h1);
        step(); rd(1, 5'd5);
        #1;
        chk("x5_after_data", rdd(1), 32'h1234);
        chk("x5_after_busy", 32'(rd_busy[1]), 32'h0);
        chk("x5_cnt0", 32'(busy_cnt), 32'h0);

        // Same-address write on both ports: port 1 wins.
        step(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
        #1 chk("x7_same", rdd(0), BYP ? 32'h22 : 32'h0);
        step(); rd(0, 5'd7); rd(1, 5'd7);
        #1;
        chk("x7_p0", rdd(0), 32'h22);
        chk("x7_p1", rdd(1), 32'h22);
        step(); rd_addr[4:0] = 5'd7;
        #1 chk("rd_en_off", rdd(0), 32'h0);

        // Issue and writeback to a busy register in the same cycle.
        step(); iss_en = 1'b1; iss_addr = 5'd9;
        step(); iss_en = 1'b1; iss_addr = 5'd9; wr(1, 5'd9, 32'hABCD);
        #1 chk("x9_cnt_pre", 32'(busy_cnt), 32'd1);
        step(); rd(0, 5'd9);
        #1;
        chk("x9_cnt", 32'(busy_cnt), 32'd1);
        chk("x9_busy", 32'(rd_busy[0]), 32'h1);
        chk("x9_data", rdd(0), 32'hABCD);
        // Clear x9 while writing idle x10: count must not go below zero.
        step(); wr(0, 5'd9, 32'h1); wr(1, 5'd10, 32'h2); rd(0, 5'd9); rd(1, 5'd10);
        #1;
        chk("x9_clr_data", rdd(0), BYP ? 32'h1 : 32'hABCD);
        chk("x9_clr_busy", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
        chk("x10_same", rdd(1), BYP ? 32'h2 : 32'h0);
        step(); rd(0, 5'd9); rd(1, 5'd10);
        #1;
        chk("x9x10_cnt", 32'(busy_cnt), 32'h0);
        chk("x9_final", rdd(0), 32'h1);
        chk("x10_final", rdd(1), 32'h2);
        chk("x9x10_busy", 32'(rd_busy), 32'h0);

        // Issuing x0 never marks anything pending.
        step(); iss_en = 1'b1; iss_addr = 5'd0;
        step(); rd(0, 5'd0);
        #1;
        chk("iss_x0_cnt", 32'(busy_cnt), 32'h0);
        chk("iss_x0_busy", 32'(rd_busy[0]), 32'h0);

        // Fill the scoreboard.
        for (int i = 1; i < 32; i++) begin
            step(); iss_en = 1'b1; iss_addr = 5'(i);
        end
        step();
        #1 chk("full_cnt", 32'(busy_cnt), 32'd31);
        step(); iss_en = 1'b1; iss_addr = 5'd5;
        step();
        #1 chk("full_reiss_cnt", 32'(busy_cnt), 32'd31);
        step(); wr(0, 5'd1, 32'hA1); wr(1, 5'd2, 32'hA2);
        step(); rd(0, 5'd1); rd(1, 5'd3);
        #1;
        chk("dual_clr_cnt", 32'(busy_cnt), 32'd29);
        chk("x1_busy", 32'(rd_busy[0]), 32'h0);
        chk("x3_busy", 32'(rd_busy[1]), 32'h1);

        // Reset with a writeback pending discards everything.
        step(); rst = 1'b1; wr(0, 5'd3, 32'h77); iss_en = 1'b1; iss_addr = 5'd4; rd(0, 5'd7);
        #1;
        chk("rst_gate_data", rdd(0), 32'h0);
        chk("rst_gate_busy", 32'(rd_busy[0]), 32'h0);
        step(); rst = 1'b0;
        #1 chk("rst2_cnt", 32'(busy_cnt), 32'h0);
        for (int a = 1; a < 32; a++) begin
            step(); rd(0, 5'(a)); rd(1, 5'(a));
            #1;
            chk("rst2_data", rdd(0), 32'h0);
            chk("rst2_busy", 32'(rd_busy), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a write-pending scoreboard, successor to the single-write, dual-read register file. It sits between ID (read ports, issue port) and MEM_WB plus any additional writeback paths (write ports). Decode uses it to read operands, mark destination registers as pending at issue, and learn whether an operand is still awaiting a writeback. Register 0 is hardwired to zero and is never marked pending.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..3); higher index = higher priority

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  port k at bits [k*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  port k at bits [k*DATA_W +: DATA_W]
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed as for wr_addr
- rd_data  out  NUM_RD*DATA_W  combinational read data
- rd_busy  out  NUM_RD  operand still pending; ID must stall
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of the issuing instruction
- busy_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, plus a busy bit per entry. Entry 0 always reads 0 and its busy bit is always 0.
- Write: on a clock edge, each port k with wr_en[k]=1 and wr_addr≠0 writes wr_data to its entry. If two ports target the same address, the highest-index port wins. Writes to address 0 are discarded.
- Busy update per entry a≠0, evaluated each edge:
  - set = iss_en && iss_addr==a
  - clr = any wr_en[k] && wr_addr[k]==a
  - If set is true, busy ← 1 (set wins over a same-cycle clear, since the new producer supersedes the old one).
  - Else if clr is true, busy ← 0.
  - Else busy holds.
- busy_cnt: registered population count of the busy bits after the update. It is updated incrementally as prev + set_applied − clr_applied, and must never underflow or exceed 2**ADDR_W−1.
- Read port j, combinational:
  - rd_en[j]=0 or rst=1 → rd_data=0 and rd_busy=0.
  - rd_addr=0 → rd_data=0 and rd_busy=0.
  - Otherwise the result follows the rules in Configuration.
- Issue and read in the same cycle to the same address: reads see the pre-issue state. The busy bit is set at the edge.

## Timing
- Read latency is 0 cycles (combinational). Write and issue take effect at the next rising edge.
- Reset: in a cycle with rst=1, every entry ← 0, every busy bit ← 0, and busy_cnt ← 0 at that edge. All wr_en and iss_en inputs are ignored during that cycle. While rst=1, rd_data=0 and rd_busy=0.
- A reset mid-operation discards all pending state. There is no recovery of in-flight writebacks.
- A write to an entry that is not busy is legal. It updates data, and busy stays 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If any write port k has wr_en[k]=1 and wr_addr[k]==rd_addr[j]≠0, rd_data[j] = the data of the highest-index matching port, and rd_busy[j]=0.
  - Otherwise rd_data[j] = the stored value, and rd_busy[j] = the stored busy bit.
- REGFILE_BYPASS_EN undefined:
  - rd_data[j] = the stored value, and rd_busy[j] = the stored busy bit.
  - A same-cycle write becomes visible on the next cycle.
- Bypass never fires for address 0 or when wr_en=0.

## Test plan
- Reset, then read all addresses on every port → rd_data=0 and busy_cnt=0. Write 0xDEADBEEF to x0 → reading x0 still returns 0.
- Issue x5 in cycle 0 → busy_cnt=1 and rd_busy=1 for x5 in cycle 1. Write x5=0x1234 on port 0 in cycle 2:
  - With bypass: rd_data=0x1234 and rd_busy=0 in cycle 2.
  - Without bypass: same values in cycle 3.
  - busy_cnt=0 in cycle 3.
- Ports 0 and 1 both write x7 (0x11 and 0x22) in one cycle → next cycle x7 reads 0x22.
- iss_en for x9 and a writeback to x9 in the same cycle (x9 previously busy) → x9 stays busy, busy_cnt unchanged, data updated.
- Issue x1..x31 on consecutive cycles → busy_cnt reaches 31. Assert rst with a write pending → the next cycle shows busy_cnt=0 and all data 0.
